// File: rtl/gpu_mem_pkg.sv
// rtl/gpu_mem_pkg.sv - shared channel states, default widths and helpers for the memory controllers
package gpu_mem_pkg;

  localparam int DEFAULT_ADDR_BITS     = 8;
  localparam int DEFAULT_DATA_BITS     = 8;
  localparam int DEFAULT_NUM_CONSUMERS = 4;
  localparam int DEFAULT_NUM_CHANNELS  = 1;

  typedef logic [2:0] ch_state_t;

  localparam ch_state_t CH_IDLE           = 3'd0;
  localparam ch_state_t CH_READ_WAITING   = 3'd1;
  localparam ch_state_t CH_WRITE_WAITING  = 3'd2;
  localparam ch_state_t CH_READ_RELAYING  = 3'd3;
  localparam ch_state_t CH_WRITE_RELAYING = 3'd4;

  // Index width that stays legal for a single-entry array.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// rtl/mem_rr_picker.sv - circular first-set search starting at ptr, one-hot grant out
module mem_rr_picker
  import gpu_mem_pkg::*;
#(
  parameter int NUM_REQ  = DEFAULT_NUM_CONSUMERS,
  parameter int PTR_BITS = idx_bits(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [PTR_BITS-1:0] ptr,
  output logic [NUM_REQ-1:0]  grant,
  output logic                grant_valid,
  output logic [PTR_BITS-1:0] grant_idx
);

  always_comb begin
    int                  sum;
    logic [PTR_BITS-1:0] slot;
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = 0;
    slot        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      slot = PTR_BITS'(sum);
      if (!grant_valid && req[slot]) begin
        grant_valid = 1'b1;
        grant[slot] = 1'b1;
        grant_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - arbitrates per-thread LSU requests onto NUM_CHANNELS memory channels
module data_mem_controller
  import gpu_mem_pkg::*;
#(
  parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int NUM_CONSUMERS = DEFAULT_NUM_CONSUMERS,
  parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS,
  parameter int WRITE_ENABLE  = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready
);

  localparam int PTR_BITS = idx_bits(NUM_CONSUMERS);
  localparam bit WR_EN    = (WRITE_ENABLE != 0);

  ch_state_t                              ch_state [NUM_CHANNELS];
  logic [PTR_BITS-1:0]                    ch_owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]               claimed;
  logic [PTR_BITS-1:0]                    rr_ptr;
  logic [PTR_BITS-1:0]                    rr_ptr_next;
  logic [NUM_CONSUMERS-1:0]               req_mask;
  logic [NUM_CONSUMERS-1:0]               avail      [NUM_CHANNELS+1];
  logic [NUM_CONSUMERS-1:0]               pick_req   [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]               pick_grant [NUM_CHANNELS];
  logic [PTR_BITS-1:0]                    pick_idx   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]                pick_valid;
  logic [NUM_CHANNELS-1:0]                mem_write_valid_q;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address_q;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data_q;
  logic [NUM_CONSUMERS-1:0]               consumer_write_ready_q;

  assign req_mask = consumer_read_valid | (WR_EN ? consumer_write_valid : '0);
  assign avail[0] = req_mask & ~claimed;

  // Channels pick in ascending order; each one masks its grant from the channels above it.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_pick
    assign pick_req[g]  = (ch_state[g] == CH_IDLE) ? avail[g] : '0;
    assign avail[g+1]   = avail[g] & ~pick_grant[g];

    mem_rr_picker #(
      .NUM_REQ (NUM_CONSUMERS),
      .PTR_BITS(PTR_BITS)
    ) u_picker (
      .req        (pick_req[g]),
      .ptr        (rr_ptr),
      .grant      (pick_grant[g]),
      .grant_valid(pick_valid[g]),
      .grant_idx  (pick_idx[g])
    );
  end

  always_comb begin
    rr_ptr_next = rr_ptr;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (pick_valid[ch]) begin
        rr_ptr_next = (pick_idx[ch] == PTR_BITS'(NUM_CONSUMERS - 1)) ? '0
                                                                     : pick_idx[ch] + PTR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        ch_state[ch] <= CH_IDLE;
        ch_owner[ch] <= '0;
      end
      claimed                <= '0;
      rr_ptr                 <= '0;
      mem_read_valid         <= '0;
      mem_read_address       <= '0;
      mem_write_valid_q      <= '0;
      mem_write_address_q    <= '0;
      mem_write_data_q       <= '0;
      consumer_read_ready    <= '0;
      consumer_read_data     <= '0;
      consumer_write_ready_q <= '0;
    end else begin
      rr_ptr <= rr_ptr_next;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (ch_state[ch])
          CH_IDLE: begin
            if (pick_valid[ch]) begin
              ch_owner[ch]          <= pick_idx[ch];
              claimed[pick_idx[ch]] <= 1'b1;
              if (consumer_read_valid[pick_idx[ch]]) begin
                ch_state[ch]         <= CH_READ_WAITING;
                mem_read_valid[ch]   <= 1'b1;
                mem_read_address[ch] <= consumer_read_address[pick_idx[ch]];
              end else begin
                ch_state[ch]            <= CH_WRITE_WAITING;
                mem_write_valid_q[ch]   <= 1'b1;
                mem_write_address_q[ch] <= consumer_write_address[pick_idx[ch]];
                mem_write_data_q[ch]    <= consumer_write_data[pick_idx[ch]];
              end
            end
          end
          CH_READ_WAITING: begin
            if (mem_read_ready[ch]) begin
              mem_read_valid[ch]                <= 1'b0;
              consumer_read_data[ch_owner[ch]]  <= mem_read_data[ch];
              consumer_read_ready[ch_owner[ch]] <= 1'b1;
              ch_state[ch]                      <= CH_READ_RELAYING;
            end
          end
          CH_WRITE_WAITING: begin
            if (mem_write_ready[ch]) begin
              mem_write_valid_q[ch]                <= 1'b0;
              consumer_write_ready_q[ch_owner[ch]] <= 1'b1;
              ch_state[ch]                         <= CH_WRITE_RELAYING;
            end
          end
          CH_READ_RELAYING: begin
            if (!consumer_read_valid[ch_owner[ch]]) begin
              consumer_read_ready[ch_owner[ch]] <= 1'b0;
              claimed[ch_owner[ch]]             <= 1'b0;
              ch_state[ch]                      <= CH_IDLE;
            end
          end
          CH_WRITE_RELAYING: begin
            if (!consumer_write_valid[ch_owner[ch]]) begin
              consumer_write_ready_q[ch_owner[ch]] <= 1'b0;
              claimed[ch_owner[ch]]                <= 1'b0;
              ch_state[ch]                         <= CH_IDLE;
            end
          end
          default: ch_state[ch] <= CH_IDLE;
        endcase
      end
    end
  end

  // Read-only instances never grant a write, so these collapse to constants.
  assign mem_write_valid      = WR_EN ? mem_write_valid_q      : '0;
  assign mem_write_address    = WR_EN ? mem_write_address_q    : '0;
  assign mem_write_data       = WR_EN ? mem_write_data_q       : '0;
  assign consumer_write_ready = WR_EN ? consumer_write_ready_q : '0;

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - randomized and directed checks of data_mem_controller against a memory model
module tb_data_mem_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance a: 2 channels, writable. Instance b: 1 channel, read-only.
  logic [3:0]      a_rv, a_rr, a_wv, a_wr, b_rv, b_rr, b_wv, b_wr;
  logic [3:0][7:0] a_ra, a_rd, a_wa, a_wd, b_ra, b_rd, b_wa, b_wd;
  logic [1:0]      a_mrv, a_mrr, a_mwv, a_mwr;
  logic [1:0][7:0] a_mra, a_mrd, a_mwa, a_mwd;
  logic [0:0]      b_mrv, b_mrr, b_mwv, b_mwr;
  logic [0:0][7:0] b_mra, b_mrd, b_mwa, b_mwd;

  data_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                        .NUM_CHANNELS(2), .WRITE_ENABLE(1)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_rv), .consumer_read_address(a_ra),
    .consumer_read_ready(a_rr), .consumer_read_data(a_rd),
    .consumer_write_valid(a_wv), .consumer_write_address(a_wa),
    .consumer_write_data(a_wd), .consumer_write_ready(a_wr),
    .mem_read_valid(a_mrv), .mem_read_address(a_mra),
    .mem_read_ready(a_mrr), .mem_read_data(a_mrd),
    .mem_write_valid(a_mwv), .mem_write_address(a_mwa),
    .mem_write_data(a_mwd), .mem_write_ready(a_mwr)
  );

  data_mem_controller #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4),
                        .NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_rv), .consumer_read_address(b_ra),
    .consumer_read_ready(b_rr), .consumer_read_data(b_rd),
    .consumer_write_valid(b_wv), .consumer_write_address(b_wa),
    .consumer_write_data(b_wd), .consumer_write_ready(b_wr),
    .mem_read_valid(b_mrv), .mem_read_address(b_mra),
    .mem_read_ready(b_mrr), .mem_read_data(b_mrd),
    .mem_write_valid(b_mwv), .mem_write_address(b_mwa),
    .mem_write_data(b_mwd), .mem_write_ready(b_mwr)
  );

  logic [7:0] mem_img [2][256];
  logic [7:0] shadow [256];
  int         lat [2];
  bit         rand_lat [2];
  bit         stray [2];
  int         mcnt [3];
  int         order_q [$];
  int         vec_cnt = 0;
  int         err_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: ready pulses for one cycle after lat waiting cycles.
  task automatic chan_step(input int inst, input logic rv, input logic [7:0] ra,
                           input logic wv, input logic [7:0] wa, input logic [7:0] wd,
                           inout logic rr, inout logic [7:0] rd, inout logic wr, inout int cnt);
    if (!reset) begin
      rr = 1'b0; wr = 1'b0; cnt = 0;
    end else if (stray[inst]) begin
      rr = 1'b1; rd = 8'hEE;
    end else if (rr || wr) begin
      rr = 1'b0; wr = 1'b0; cnt = 0;
      if (rand_lat[inst]) lat[inst] = $urandom_range(0, 3);
    end else if (rv || wv) begin
      if (cnt >= lat[inst]) begin
        if (rv) begin rr = 1'b1; rd = mem_img[inst][ra]; end
        else begin wr = 1'b1; mem_img[inst][wa] = wd; end
      end else cnt++;
    end
  endtask

  always @(negedge clk) begin
    chan_step(0, a_mrv[0], a_mra[0], a_mwv[0], a_mwa[0], a_mwd[0], a_mrr[0], a_mrd[0], a_mwr[0], mcnt[0]);
    chan_step(0, a_mrv[1], a_mra[1], a_mwv[1], a_mwa[1], a_mwd[1], a_mrr[1], a_mrd[1], a_mwr[1], mcnt[1]);
    chan_step(1, b_mrv[0], b_mra[0], b_mwv[0], b_mwa[0], b_mwd[0], b_mrr[0], b_mrd[0], b_mwr[0], mcnt[2]);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    a_rv = '0; a_wv = '0; b_rv = '0; b_wv = '0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic b_reader(input int id, input int nreq);
    for (int n = 0; n < nreq; n++) begin
      bit got;
      logic [7:0] addr;
      addr = 8'h40 + 8'(id);
      b_ra[id] = addr; b_rv[id] = 1'b1; got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin @(negedge clk); got = b_rr[id]; end
      chk("ord_done", 32'(got), 1);
      if (got) order_q.push_back(id);
      chk("ord_data", b_rd[id], mem_img[1][addr]);
      b_rv[id] = 1'b0;
      @(negedge clk);
      chk("ord_release", b_rr[id], 0);
    end
  endtask

  task automatic a_wr_wait(input int id);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin @(negedge clk); got = a_wr[id]; end
    chk("w4_done", 32'(got), 1);
    a_wv[id] = 1'b0;
  endtask

  task automatic a_agent(input int id);
    for (int t = 0; t < 15; t++) begin
      logic [7:0] addr, data;
      bit is_wr, got;
      addr  = {id[1:0], 6'($urandom)};
      data  = 8'($urandom);
      is_wr = 1'($urandom_range(0, 1));
      if (is_wr) begin
        a_wa[id] = addr; a_wd[id] = data; a_wv[id] = 1'b1; shadow[addr] = data;
      end else begin
        a_ra[id] = addr; a_rv[id] = 1'b1;
      end
      got = 1'b0;
      for (int k = 0; k < 80 && !got; k++) begin
        @(negedge clk);
        got = is_wr ? a_wr[id] : a_rr[id];
      end
      chk("rnd_done", 32'(got), 1);
      chk("rnd_excl", 32'(a_rr[id] & a_wr[id]), 0);
      if (!is_wr) chk("rnd_rd_data", a_rd[id], shadow[addr]);
      a_wv[id] = 1'b0; a_rv[id] = 1'b0;
      @(negedge clk);
      chk("rnd_release", 32'(a_rr[id] | a_wr[id]), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, vectors %0d", vec_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int         exp_order [5];
    logic [7:0] w_addr [4];
    logic [7:0] w_data [4];
    bit         seen_mwv, seen_wr, got_rd;
    logic [7:0] rdat;

    a_rv = '0; a_ra = '0; a_wv = '0; a_wa = '0; a_wd = '0;
    b_rv = '0; b_ra = '0; b_wv = '0; b_wa = '0; b_wd = '0;
    a_mrr = '0; a_mrd = '0; a_mwr = '0; b_mrr = '0; b_mrd = '0; b_mwr = '0;
    for (int i = 0; i < 2; i++) begin
      lat[i] = 0; rand_lat[i] = 1'b0; stray[i] = 1'b0;
      for (int a = 0; a < 256; a++) mem_img[i][a] = 8'($urandom);
    end
    for (int i = 0; i < 3; i++) mcnt[i] = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_a_mrv", a_mrv, 0);
    chk("rst_a_mwv", a_mwv, 0);
    chk("rst_a_rr", a_rr, 0);
    chk("rst_a_wr", a_wr, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_a_mra", a_mra, 0);
    chk("rst_b_mrv", b_mrv, 0);
    chk("rst_b_rr", b_rr, 0);
    reset = 1'b1;

    // Single read at minimum latency
    mem_img[1][8'h10] = 8'hA5;
    @(negedge clk);
    b_ra[0] = 8'h10; b_rv[0] = 1'b1;
    @(negedge clk);
    chk("rd1_mrv", b_mrv, 1);
    chk("rd1_mra", b_mra[0], 8'h10);
    chk("rd1_early", b_rr, 0);
    @(negedge clk);
    chk("rd1_rdy", b_rr, 4'b0001);
    chk("rd1_data", b_rd[0], 8'hA5);
    chk("rd1_mrv_drop", b_mrv, 0);
    b_rv[0] = 1'b0;
    @(negedge clk);
    chk("rd1_release", b_rr, 0);

    // Single-channel contention with wrap
    do_reset();
    exp_order = '{0, 1, 2, 3, 0};
    fork
      b_reader(0, 2);
      b_reader(1, 1);
      b_reader(2, 1);
      b_reader(3, 1);
    join
    chk("order_len", order_q.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("order", (i < order_q.size()) ? order_q[i] : 99, exp_order[i]);

    // Two channels, four writers
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w_addr[i] = 8'h90 + 8'(i * 5);
      w_data[i] = 8'($urandom);
      mem_img[0][w_addr[i]] = ~w_data[i];
      a_wa[i] = w_addr[i]; a_wd[i] = w_data[i];
    end
    a_wv = 4'hF;
    @(negedge clk);
    chk("w4_mwv", a_mwv, 2'b11);
    chk("w4_mwa0", a_mwa[0], w_addr[0]);
    chk("w4_mwa1", a_mwa[1], w_addr[1]);
    chk("w4_mwd0", a_mwd[0], w_data[0]);
    chk("w4_mwd1", a_mwd[1], w_data[1]);
    fork
      a_wr_wait(0);
      a_wr_wait(1);
      a_wr_wait(2);
      a_wr_wait(3);
    join
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("w4_mem", mem_img[0][w_addr[i]], w_data[i]);

    // Backpressure
    lat[1] = 5;
    do_reset();
    b_ra[0] = 8'h33; b_rv[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("bp_hold", {b_mrv, b_mra[0], b_rr[0]}, {1'b1, 8'h33, 1'b0});
    end
    @(negedge clk);
    chk("bp_rdy", b_rr, 4'b0001);
    chk("bp_data", b_rd[0], mem_img[1][8'h33]);
    b_rv[0] = 1'b0;
    @(negedge clk);

    // Reset while waiting on memory
    lat[1] = 20;
    do_reset();
    b_ra[0] = 8'h22; b_rv[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rw_wait", b_mrv, 1);
    reset = 1'b0; b_rv[0] = 1'b0;
    @(negedge clk);
    chk("rw_mrv", b_mrv, 0);
    chk("rw_mra", b_mra, 0);
    chk("rw_rr", b_rr, 0);
    chk("rw_rd", b_rd, 0);
    reset = 1'b1; stray[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) stray[1] = 1'b0;
      chk("rw_stray", {b_rr, b_mrv}, 0);
    end
    lat[1] = 0;

    // Read-only instance ignores writes
    do_reset();
    mem_img[1][8'h20] = 8'hAA;
    b_wa[1] = 8'h20; b_wd[1] = 8'h55; b_wv[1] = 1'b1;
    b_ra[2] = 8'h21; b_rv[2] = 1'b1;
    seen_mwv = 1'b0; seen_wr = 1'b0; got_rd = 1'b0; rdat = '0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen_mwv |= b_mwv[0];
      seen_wr  |= (b_wr != 0);
      if (b_rr[2] && !got_rd) begin got_rd = 1'b1; rdat = b_rd[2]; b_rv[2] = 1'b0; end
    end
    chk("ro_mwv", 32'(seen_mwv), 0);
    chk("ro_wr", 32'(seen_wr), 0);
    chk("ro_rd_done", 32'(got_rd), 1);
    chk("ro_rd_data", rdat, mem_img[1][8'h21]);
    chk("ro_mem", mem_img[1][8'h20], 8'hAA);
    b_wv[1] = 1'b0;

    // Read wins over write from the same consumer
    do_reset();
    a_ra[0] = 8'h05; a_rv[0] = 1'b1;
    a_wa[0] = 8'h06; a_wd[0] = 8'h77; a_wv[0] = 1'b1;
    @(negedge clk);
    chk("rw_pri_mrv", a_mrv, 2'b01);
    chk("rw_pri_mwv", a_mwv, 0);
    @(negedge clk);
    chk("rw_pri_rdy", {a_rr[0], a_wr[0]}, 2'b10);
    chk("rw_pri_data", a_rd[0], mem_img[0][8'h05]);
    a_rv[0] = 1'b0; a_wv[0] = 1'b0;
    @(negedge clk);

    // Randomized traffic, four agents on two channels
    do_reset();
    rand_lat[0] = 1'b1;
    for (int a = 0; a < 256; a++) shadow[a] = mem_img[0][a];
    fork
      a_agent(0);
      a_agent(1);
      a_agent(2);
      a_agent(3);
    join

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
